// File: rtl/hamming_pkg.sv
// Hamming(7,4) codeword layout and decode helpers shared by the receive-side
// byte assembler and the transmit-side encoder.
package hamming_pkg;

    // Bit index of each codeword position (position k lives at bit k-1).
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D1 = 2;
    localparam int P4 = 3;
    localparam int D2 = 4;
    localparam int D3 = 5;
    localparam int D4 = 6;

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } asm_state_t;

    // Syndrome value equals the 1-based position of a single flipped bit.
    function automatic logic [2:0] hamming_syndrome(input logic [6:0] c);
        logic s1, s2, s4;
        s1 = c[P1] ^ c[D1] ^ c[D2] ^ c[D4];
        s2 = c[P2] ^ c[D1] ^ c[D3] ^ c[D4];
        s4 = c[P4] ^ c[D2] ^ c[D3] ^ c[D4];
        return {s4, s2, s1};
    endfunction

    function automatic logic [6:0] hamming_correct(input logic [6:0] c);
        logic [2:0] syn;
        logic [6:0] fixed;
        syn   = hamming_syndrome(c);
        fixed = c;
        if (syn != 3'd0) begin
            fixed[syn - 3'd1] = ~fixed[syn - 3'd1];
        end
        return fixed;
    endfunction

    function automatic logic [3:0] hamming_data(input logic [6:0] c);
        return {c[D4], c[D3], c[D2], c[D1]};
    endfunction

endpackage

// File: rtl/hamming_byte_assembler_byte_fifo.sv
// First-word-fall-through FIFO holding {corr, byte} entries; a pop on the same
// edge frees the slot for a push even when full.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_CNT);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; the count alone decides
    // which entries are live, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/hamming_byte_assembler.sv
// Registers received Hamming(7,4) codewords, corrects single-bit errors, pairs
// nibbles (low first) into bytes and queues them behind a valid/ready FIFO.
module hamming_byte_assembler
    import hamming_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [6:0]       in_data,
    input  logic             in_valid,
    input  logic             sync_clr,
    output logic [7:0]       out_data,
    output logic             out_corr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] corr_count,
    output logic             half_pending
);

    logic [6:0]       r_cw;
    logic             r_cw_v;
    asm_state_t       r_state;
    asm_state_t       w_state_next;
    logic [3:0]       r_lo_nib;
    logic             r_lo_corr;
    logic [CNT_W-1:0] r_corr_count;
    logic             r_overflow;

    logic [3:0]       w_nib;
    logic             w_corr;
    logic             w_lo_load;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic [8:0]       w_push_data;
    logic [8:0]       w_head;
    logic             w_full;
    logic             w_empty;

    // NOTE: every clocked register here uses non-blocking assignment so all
    // stages see pre-edge values and the pipeline order cannot race.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cw   <= '0;
            r_cw_v <= 1'b0;
        end else begin
            r_cw_v <= ena && in_valid;
            if (ena && in_valid) begin
                r_cw <= in_data;
            end
        end
    end

    assign w_corr = (hamming_syndrome(r_cw) != 3'd0);
    assign w_nib  = hamming_data(hamming_correct(r_cw));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= LOW;
            r_lo_nib  <= '0;
            r_lo_corr <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_lo_load) begin
                r_lo_nib  <= w_nib;
                r_lo_corr <= w_corr;
            end
        end
    end

    // NOTE: defaults first so no path through this block leaves a latch.
    always_comb begin
        w_state_next = r_state;
        w_lo_load    = 1'b0;
        w_push       = 1'b0;
        if (r_cw_v) begin
            // sync_clr restarts pairing, so a coincident nibble becomes a new low half.
            if (sync_clr || r_state == LOW) begin
                w_lo_load    = 1'b1;
                w_state_next = HIGH;
            end else begin
                w_push       = 1'b1;
                w_state_next = LOW;
            end
        end else if (sync_clr) begin
            w_state_next = LOW;
        end
    end

    assign w_push_data = {r_lo_corr | w_corr, w_nib, r_lo_nib};
    assign w_pop       = out_ready && !w_empty;
    assign w_drop      = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_corr_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (r_cw_v && w_corr && r_corr_count != {CNT_W{1'b1}}) begin
                r_corr_count <= r_corr_count + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Stale storage is masked so an empty FIFO always presents zeros.
    assign out_valid    = !w_empty;
    assign out_data     = w_empty ? 8'h00 : w_head[7:0];
    assign out_corr     = !w_empty && w_head[8];
    assign overflow     = r_overflow;
    assign corr_count   = r_corr_count;
    assign half_pending = (r_state == HIGH);

endmodule

// File: tb/tb_hamming_byte_assembler.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a nearest-codeword reference.
module tb_hamming_byte_assembler;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b1;
    logic [6:0]       in_data = '0;
    logic             in_valid = 1'b0;
    logic             sync_clr = 1'b0;
    logic [7:0]       out_data;
    logic             out_corr;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             overflow;
    logic [CNT_W-1:0] corr_count;
    logic             half_pending;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // Reference state: one-cycle capture register, pending half, byte queue.
    logic       m_cw_v = 1'b0;
    logic [6:0] m_cw   = '0;
    logic       m_half = 1'b0;
    logic [3:0] m_lo   = '0;
    logic       m_lo_c = 1'b0;
    logic [8:0] m_q[$];
    logic       m_ovf  = 1'b0;
    int         m_cnt  = 0;

    hamming_byte_assembler #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .sync_clr     (sync_clr),
        .out_data     (out_data),
        .out_corr     (out_corr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow),
        .corr_count   (corr_count),
        .half_pending (half_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Encoder written straight from the parity equations.
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        return c;
    endfunction

    // Perfect code: every word lies within distance 1 of exactly one codeword.
    task automatic decode(input logic [6:0] c, output logic [3:0] nib, output logic corr);
        nib  = '0;
        corr = 1'b0;
        for (int d = 0; d < 16; d++) begin
            if ($countones(enc(4'(d)) ^ c) <= 1) begin
                nib  = 4'(d);
                corr = (enc(4'(d)) != c);
            end
        end
    endtask

    task automatic model_step();
        logic [3:0] nib;
        logic       corr;
        if (rst) begin
            m_cw_v = 1'b0;
            m_cw   = '0;
            m_half = 1'b0;
            m_lo   = '0;
            m_lo_c = 1'b0;
            m_q.delete();
            m_ovf  = 1'b0;
            m_cnt  = 0;
        end else begin
            if (m_q.size() != 0 && out_ready) begin
                void'(m_q.pop_front());
            end
            if (m_cw_v) begin
                decode(m_cw, nib, corr);
                if (corr && m_cnt < CNT_MAX) m_cnt++;
                if (sync_clr || !m_half) begin
                    m_lo   = nib;
                    m_lo_c = corr;
                    m_half = 1'b1;
                end else begin
                    m_half = 1'b0;
                    if (m_q.size() < DEPTH) m_q.push_back({m_lo_c | corr, nib, m_lo});
                    else                    m_ovf = 1'b1;
                end
            end else if (sync_clr) begin
                m_half = 1'b0;
            end
            m_cw_v = ena && in_valid;
            if (m_cw_v) m_cw = in_data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic pulse(input logic [6:0] cw);
        in_data  = cw;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [8:0] head;
            head = (m_q.size() != 0) ? m_q[0] : 9'h000;
            check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
            check("out_data", 32'(out_data), 32'(head[7:0]));
            check("out_corr", 32'(out_corr), 32'(head[8]));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("corr_count", 32'(corr_count), 32'(m_cnt));
            check("half_pending", 32'(half_pending), 32'(m_half));
        end
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_corr_count", 32'(corr_count), 32'd0);
        rst = 1'b0;

        // Clean pair 0x6 then 0x9.
        pulse(7'b0110011);
        pulse(7'b1001100);
        check("clean_half", 32'(half_pending), 32'd1);
        check("clean_latency", 32'(out_valid), 32'd0);
        tick();
        check("clean_valid", 32'(out_valid), 32'd1);
        check("clean_data", 32'(out_data), 32'h96);
        check("clean_corr", 32'(out_corr), 32'd0);
        check("clean_count", 32'(corr_count), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("clean_popped", 32'(out_valid), 32'd0);

        // 0x6 with bit 4 flipped (syndrome 5), then clean 0x9.
        pulse(7'b0100011);
        pulse(7'b1001100);
        tick();
        check("err_data", 32'(out_data), 32'h96);
        check("err_corr", 32'(out_corr), 32'd1);
        check("err_count", 32'(corr_count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Five bytes into a four-deep FIFO with no consumer.
        for (int k = 1; k <= 5; k++) begin
            pulse(enc(4'(k)));
            pulse(enc(4'(k)));
        end
        tick();
        check("ovf_flag", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("ovf_order", 32'(out_data), 32'(8'h11 * k));
            tick();
        end
        out_ready = 1'b0;
        check("ovf_drained", 32'(out_valid), 32'd0);

        // Full FIFO with a pop on the same edge as the fifth push.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            pulse(enc(4'(k)));
            pulse(enc(4'(k)));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("full_pp_ovf", 32'(overflow), 32'd0);
        check("full_pp_head", 32'(out_data), 32'h22);
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check("full_pp_order", 32'(out_data), 32'(8'h11 * k));
            tick();
        end
        out_ready = 1'b0;
        check("full_pp_empty", 32'(out_valid), 32'd0);

        // sync_clr drops a pending nibble; ena low blocks capture.
        pulse(enc(4'h3));
        tick();
        check("sync_half_set", 32'(half_pending), 32'd1);
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        check("sync_half_clr", 32'(half_pending), 32'd0);
        ena = 1'b0;
        pulse(enc(4'h1));
        pulse(enc(4'h2));
        tick();
        tick();
        check("ena_no_out", 32'(out_valid), 32'd0);
        check("ena_no_half", 32'(half_pending), 32'd0);
        ena = 1'b1;
        pulse(enc(4'h7));
        pulse(enc(4'hA));
        tick();
        check("ena_byte", 32'(out_data), 32'hA7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset with two bytes queued and a nibble pending.
        for (int k = 0; k < 5; k++) pulse(enc(4'(k + 2)));
        tick();
        check("pre_rst_half", 32'(half_pending), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_half", 32'(half_pending), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);

        // Corrected-error counter saturation.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            in_data = enc(4'(i % 16)) ^ (7'b1 << (i % 7));
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("sat_count", 32'(corr_count), 32'(CNT_MAX));

        // Randomized traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] cw;
            int e;
            cw = enc(4'($urandom_range(0, 15)));
            e  = $urandom_range(0, 9);
            if (e >= 6) cw = cw ^ (7'b1 << $urandom_range(0, 6));
            if (e == 9) cw = cw ^ (7'b1 << $urandom_range(0, 6));
            in_data   = cw;
            in_valid  = ($urandom_range(0, 2) != 0);
            ena       = ($urandom_range(0, 9) != 0);
            sync_clr  = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            rst       = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        sync_clr = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
